reg_file_sb: RTL and testbench

REG_FILE_SB -- requirements
Module: reg_file_sb

---
 rtl/reg_file_sb_pkg.sv | 12 +
 rtl/reg_scoreboard.sv | 65 ++++++
 rtl/reg_file_sb.sv | 94 +++++++++
 tb/tb_reg_file_sb.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/reg_file_sb_pkg.sv
// Shared defaults and index-width derivation for the scoreboarded register file.
package reg_file_sb_pkg;

    localparam int XLEN_DEF = 32;
    localparam int NREG_DEF = 32;

    // Index width for a register count (count is a power of two, at least 2).
    function automatic int aw_of(input int nreg);
        return $clog2(nreg);
    endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register pending-producer bits plus a registered count of set bits.
module reg_scoreboard
    import reg_file_sb_pkg::*;
#(
    parameter int NREG = NREG_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    iss_en,
    input  logic [aw_of(NREG)-1:0]  iss_addr,
    input  logic                    wr_en,
    input  logic [aw_of(NREG)-1:0]  wr_addr,
    input  logic                    flush,
    input  logic [aw_of(NREG)-1:0]  rs1_addr,
    input  logic [aw_of(NREG)-1:0]  rs2_addr,
    output logic                    rs1_raw_busy,
    output logic                    rs2_raw_busy,
    output logic [aw_of(NREG):0]    pend_cnt
);

    localparam int AW = aw_of(NREG);
    localparam int CW = AW + 1;

    logic [NREG-1:0] busy_d;
    logic [NREG-1:0] busy_q;
    logic [CW-1:0]   cnt_d;
    logic [CW-1:0]   cnt_q;

    // Next busy vector: flush beats issue, issue beats writeback; index 0 never sets.
    always_comb begin
        busy_d = busy_q;
        cnt_d  = {CW{1'b0}};
        for (int i = 0; i < NREG; i++) begin
            if (flush) begin
                busy_d[i] = 1'b0;
            end else if (iss_en && (iss_addr == AW'(i))) begin
                busy_d[i] = 1'b1;
            end else if (wr_en && (wr_addr == AW'(i))) begin
                busy_d[i] = 1'b0;
            end else begin
                busy_d[i] = busy_q[i];
            end
        end
        busy_d[0] = 1'b0;
        for (int i = 0; i < NREG; i++) begin
            cnt_d = cnt_d + CW'(busy_d[i]);
        end
    end

    // Busy bits and their population count update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= {NREG{1'b0}};
            cnt_q  <= {CW{1'b0}};
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign rs1_raw_busy = busy_q[rs1_addr];
    assign rs2_raw_busy = busy_q[rs2_addr];
    assign pend_cnt     = cnt_q;

endmodule

// File: rtl/reg_file_sb.sv
// Two-read/one-write register file with optional write-to-read forwarding
// and a reservation scoreboard for hazard stalls.
module reg_file_sb
    import reg_file_sb_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int NREG   = NREG_DEF,
    parameter int BYPASS = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [aw_of(NREG)-1:0]  rs1_addr,
    input  logic [aw_of(NREG)-1:0]  rs2_addr,
    output logic [XLEN-1:0]         rd1_data,
    output logic [XLEN-1:0]         rd2_data,
    input  logic                    wr_en,
    input  logic [aw_of(NREG)-1:0]  wr_addr,
    input  logic [XLEN-1:0]         wr_data,
    input  logic                    iss_en,
    input  logic [aw_of(NREG)-1:0]  iss_addr,
    input  logic                    flush,
    output logic                    rs1_busy,
    output logic                    rs2_busy,
    output logic                    stall,
    output logic [aw_of(NREG):0]    pend_cnt
);

    localparam int AW = aw_of(NREG);

    logic [XLEN-1:0] regs_q [NREG];
    logic            rs1_raw_busy_s;
    logic            rs2_raw_busy_s;
    logic            wr_live_s;
    logic            fwd1_s;
    logic            fwd2_s;

    assign wr_live_s = wr_en && (wr_addr != {AW{1'b0}});
    assign fwd1_s    = (BYPASS != 0) && wr_live_s && (wr_addr == rs1_addr);
    assign fwd2_s    = (BYPASS != 0) && wr_live_s && (wr_addr == rs2_addr);

    // Register storage; x0 is never written.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= {XLEN{1'b0}};
            end
        end else if (wr_live_s) begin
            regs_q[wr_addr] <= wr_data;
        end
    end

    // Read ports: reset and x0 force zero ahead of forwarding.
    always_comb begin
        rd1_data = {XLEN{1'b0}};
        rd2_data = {XLEN{1'b0}};
        if (rst || (rs1_addr == {AW{1'b0}})) begin
            rd1_data = {XLEN{1'b0}};
        end else if (fwd1_s) begin
            rd1_data = wr_data;
        end else begin
            rd1_data = regs_q[rs1_addr];
        end
        if (rst || (rs2_addr == {AW{1'b0}})) begin
            rd2_data = {XLEN{1'b0}};
        end else if (fwd2_s) begin
            rd2_data = wr_data;
        end else begin
            rd2_data = regs_q[rs2_addr];
        end
    end

    reg_scoreboard #(
        .NREG(NREG)
    ) u_sb (
        .clk          (clk),
        .rst          (rst),
        .iss_en       (iss_en),
        .iss_addr     (iss_addr),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .flush        (flush),
        .rs1_addr     (rs1_addr),
        .rs2_addr     (rs2_addr),
        .rs1_raw_busy (rs1_raw_busy_s),
        .rs2_raw_busy (rs2_raw_busy_s),
        .pend_cnt     (pend_cnt)
    );

    // A forwarded source is no longer waiting on its producer.
    assign rs1_busy = rs1_raw_busy_s && !fwd1_s;
    assign rs2_busy = rs2_raw_busy_s && !fwd2_s;
    assign stall    = rs1_busy || rs2_busy;

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench: one forwarding and one non-forwarding instance share stimulus.
module tb_reg_file_sb;

    logic        clk;
    logic        rst;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        iss_en;
    logic [4:0]  iss_addr;
    logic        flush;

    logic [31:0] rd1_data, rd2_data, rd1_nb, rd2_nb;
    logic        rs1_busy, rs2_busy, stall, rs1_busy_nb, rs2_busy_nb, stall_nb;
    logic [5:0]  pend_cnt, pend_nb;

    int n_vec  = 0;
    int n_miss = 0;

    reg_file_sb #(.XLEN(32), .NREG(32), .BYPASS(1)) u_dut (
        .clk(clk), .rst(rst), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rd1_data(rd1_data), .rd2_data(rd2_data), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .iss_en(iss_en),
        .iss_addr(iss_addr), .flush(flush), .rs1_busy(rs1_busy),
        .rs2_busy(rs2_busy), .stall(stall), .pend_cnt(pend_cnt)
    );

    reg_file_sb #(.XLEN(32), .NREG(32), .BYPASS(0)) u_dut_nb (
        .clk(clk), .rst(rst), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rd1_data(rd1_nb), .rd2_data(rd2_nb), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .iss_en(iss_en),
        .iss_addr(iss_addr), .flush(flush), .rs1_busy(rs1_busy_nb),
        .rs2_busy(rs2_busy_nb), .stall(stall_nb), .pend_cnt(pend_nb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en  = 1'b0;
        iss_en = 1'b0;
        flush  = 1'b0;
    endtask

    initial begin
        rst = 1'b1; idle();
        rs1_addr = 5'd5; rs2_addr = 5'd0;
        wr_addr = 5'd5; wr_data = 32'hCAFE_F00D; wr_en = 1'b1;
        iss_addr = 5'd0;
        #2;
        check_vec("rst_rd1_fwd_masked", rd1_data, 32'h0);
        check_vec("rst_pend", {26'd0, pend_cnt}, 32'd0);

        // release reset between edges, then write x5
        #6 rst = 1'b0;
        rs1_addr = 5'd0; wr_addr = 5'd5; wr_data = 32'hDEAD_BEEF; wr_en = 1'b1;
        step();
        idle(); rs1_addr = 5'd5; #1;
        check_vec("x5_read", rd1_data, 32'hDEAD_BEEF);
        check_vec("x5_read_nb", rd1_nb, 32'hDEAD_BEEF);

        // write to x0 is discarded, no forwarding from x0
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFF_FFFF; rs2_addr = 5'd0; #1;
        check_vec("x0_fwd", rd2_data, 32'h0);
        step();
        idle(); #1;
        check_vec("x0_read", rd2_data, 32'h0);

        // x7 = 0x1111 with same-cycle issue: issue wins, bit ends set
        rs1_addr = 5'd0;
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h0000_1111;
        iss_en = 1'b1; iss_addr = 5'd7;
        step();
        idle(); #1;
        check_vec("x7_pend", {26'd0, pend_cnt}, 32'd1);

        // forwarding cycle on x7
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h0000_1234; rs2_addr = 5'd7; #1;
        check_vec("byp_rd2", rd2_data, 32'h0000_1234);
        check_vec("byp_busy2", {31'd0, rs2_busy}, 32'd0);
        check_vec("byp_stall", {31'd0, stall}, 32'd0);
        check_vec("nb_rd2_old", rd2_nb, 32'h0000_1111);
        check_vec("nb_busy2", {31'd0, rs2_busy_nb}, 32'd1);
        check_vec("nb_stall", {31'd0, stall_nb}, 32'd1);
        step();
        idle(); #1;
        check_vec("x7_after_wr", rd2_nb, 32'h0000_1234);
        check_vec("x7_pend_clr", {26'd0, pend_cnt}, 32'd0);

        // issue x3, observe hazard, then retire it
        rs2_addr = 5'd0;
        iss_en = 1'b1; iss_addr = 5'd3;
        step();
        idle(); rs1_addr = 5'd3; #1;
        check_vec("x3_busy", {31'd0, rs1_busy}, 32'd1);
        check_vec("x3_stall", {31'd0, stall}, 32'd1);
        check_vec("x3_pend", {26'd0, pend_cnt}, 32'd1);
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h0000_0033;
        step();
        idle(); #1;
        check_vec("x3_busy_clr", {31'd0, rs1_busy}, 32'd0);
        check_vec("x3_pend_clr", {26'd0, pend_cnt}, 32'd0);
        check_vec("x3_data", rd1_data, 32'h0000_0033);

        // x4 busy, then same-cycle issue + write: data lands, bit stays set
        iss_en = 1'b1; iss_addr = 5'd4;
        step();
        idle();
        iss_en = 1'b1; iss_addr = 5'd4;
        wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'h0000_0044;
        step();
        idle(); rs1_addr = 5'd4; #1;
        check_vec("x4_data", rd1_data, 32'h0000_0044);
        check_vec("x4_busy", {31'd0, rs1_busy}, 32'd1);
        check_vec("x4_pend", {26'd0, pend_cnt}, 32'd1);
        wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'h0000_0045;
        step();
        idle();

        // issue x1, x2, x3 then re-issue x2
        for (int i = 1; i <= 3; i++) begin
            iss_en = 1'b1; iss_addr = 5'(i);
            step();
        end
        idle(); #1;
        check_vec("pend_3", {26'd0, pend_cnt}, 32'd3);
        iss_en = 1'b1; iss_addr = 5'd2;
        step();
        idle(); #1;
        check_vec("reissue_pend", {26'd0, pend_cnt}, 32'd3);

        // flush overrides a concurrent issue; write still lands
        flush = 1'b1; iss_en = 1'b1; iss_addr = 5'd6;
        wr_en = 1'b1; wr_addr = 5'd1; wr_data = 32'h0000_0099;
        step();
        idle(); rs1_addr = 5'd6; rs2_addr = 5'd1; #1;
        check_vec("flush_pend", {26'd0, pend_cnt}, 32'd0);
        check_vec("flush_busy6", {31'd0, rs1_busy}, 32'd0);
        check_vec("flush_busy1", {31'd0, rs2_busy}, 32'd0);
        check_vec("flush_wr", rd2_data, 32'h0000_0099);

        // two reservations, then asynchronous reset mid-cycle
        iss_en = 1'b1; iss_addr = 5'd1;
        step();
        iss_addr = 5'd2;
        step();
        idle(); rs1_addr = 5'd1; rs2_addr = 5'd5; #1;
        check_vec("pre_rst_pend", {26'd0, pend_cnt}, 32'd2);
        check_vec("pre_rst_x5", rd2_data, 32'hDEAD_BEEF);
        #2 rst = 1'b1;
        #1;
        check_vec("arst_pend", {26'd0, pend_cnt}, 32'd0);
        check_vec("arst_busy", {31'd0, rs1_busy}, 32'd0);
        check_vec("arst_rd2", rd2_data, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h0000_0ABC;
        step();
        idle(); rs1_addr = 5'd9; #1;
        check_vec("post_rst_wr", rd1_data, 32'h0000_0ABC);
        check_vec("post_rst_x5", rd2_data, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
